// File: rtl/cycle_watch_if.sv
// cycle_watch_if: run-control / cycle-accounting bus between the core side and cycle_watch.
`timescale 1ns/1ps

interface cycle_watch_if #(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned PC_W   = 32
);
  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PC_W-1:0]   pc_i;
  logic [NUM_CH-1:0] ev_i;
  logic              clear_i;
  logic              freeze_i;
  logic [SEL_W-1:0]  sel_i;
  logic [CNT_W-1:0]  cycle_cnt_o;
  logic [CNT_W-1:0]  ch_cnt_o;
  logic              stall_o;
  logic              stall_seen_o;
  logic [PC_W-1:0]   stall_pc_o;

  modport master (
    output pc_i, ev_i, clear_i, freeze_i, sel_i,
    input  cycle_cnt_o, ch_cnt_o, stall_o, stall_seen_o, stall_pc_o
  );

  modport slave (
    input  pc_i, ev_i, clear_i, freeze_i, sel_i,
    output cycle_cnt_o, ch_cnt_o, stall_o, stall_seen_o, stall_pc_o
  );
endinterface

// File: rtl/cycle_watch.sv
// cycle_watch: stretched SoC reset, cycle/event counting and PC-stall detection.
// Optional feature macro CYCLE_WATCH_SAT_EN: counters saturate instead of wrapping.
`timescale 1ns/1ps

module cycle_watch #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned STALL_LIMIT = 1024,
  parameter int unsigned RST_HOLD    = 16
) (
  input  logic          clk_in,
  input  logic          rst_n,
  output logic          sys_rst_n_o,
  cycle_watch_if.slave  bus
);
  localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned HOLD_W  = $clog2(RST_HOLD + 1);
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT);
  localparam logic [STALL_W-1:0] LIMIT_M1 = STALL_W'(STALL_LIMIT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_M1  = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_STALL} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [1:0]          r_sync;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic                r_sys_rst_n;
  logic [PC_W-1:0]     r_pc_prev;
  logic [STALL_W-1:0]  r_stall_cnt;
  logic [STALL_W-1:0]  w_stall_cnt_nxt;
  logic                w_pc_eq;
  logic                w_active;
  logic                w_enter_stall;
  logic [CNT_W-1:0]    r_cycle_cnt;
  logic [CNT_W-1:0]    r_ch_cnt [NUM_CH];
  logic [CNT_W-1:0]    w_ch_cnt;
  logic                r_stall;
  logic                r_stall_seen;
  logic [PC_W-1:0]     r_stall_pc;

  // Counter increment: wraps by default, saturates at all-ones when enabled.
  function automatic logic [CNT_W-1:0] f_inc(input logic [CNT_W-1:0] v);
`ifdef CYCLE_WATCH_SAT_EN
    return (v == '1) ? v : v + CNT_W'(1);
`else
    return v + CNT_W'(1);
`endif
  endfunction

  // Two-flop reset synchroniser; asserts asynchronously, releases on clk_in.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], 1'b1};
  end

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= ST_HOLD;
    else        r_state <= w_next_state;
  end

  // Next state, stall-counter update and stall-entry strobe.
  always_comb begin
    w_next_state    = r_state;
    w_active        = 1'b0;
    w_enter_stall   = 1'b0;
    w_pc_eq         = (bus.pc_i == r_pc_prev);
    w_stall_cnt_nxt = '0;
    if (w_pc_eq) begin
      w_stall_cnt_nxt = (r_stall_cnt == LIMIT_M1) ? r_stall_cnt : r_stall_cnt + STALL_W'(1);
    end
    case (r_state)
      ST_HOLD: begin
        if (r_sync[1] && (r_hold_cnt == HOLD_M1)) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        w_active = 1'b1;
        if (!bus.clear_i && w_pc_eq && (w_stall_cnt_nxt == LIMIT_M1)) begin
          w_next_state  = ST_STALL;
          w_enter_stall = 1'b1;
        end
      end
      ST_STALL: begin
        w_active = 1'b1;
        if (bus.clear_i || !w_pc_eq) w_next_state = ST_RUN;
      end
      default: w_next_state = ST_HOLD;
    endcase
  end

  // Hold counter runs once the synchroniser output is high; registered status outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt  <= '0;
      r_sys_rst_n <= 1'b0;
      r_stall     <= 1'b0;
      r_pc_prev   <= '0;
    end else begin
      if ((r_state == ST_HOLD) && r_sync[1]) r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      r_sys_rst_n <= (w_next_state != ST_HOLD);
      r_stall     <= (w_next_state == ST_STALL);
      r_pc_prev   <= bus.pc_i;
    end
  end

  // Consecutive unchanged-PC counter, only meaningful outside HOLD.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                     r_stall_cnt <= '0;
    else if (!w_active || bus.clear_i) r_stall_cnt <= '0;
    else                            r_stall_cnt <= w_stall_cnt_nxt;
  end

  // Cycle and per-channel event counters; clear beats increment, freeze pauses.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      for (int k = 0; k < int'(NUM_CH); k++) r_ch_cnt[k] <= '0;
    end else if (w_active) begin
      if (bus.clear_i) begin
        r_cycle_cnt <= '0;
        for (int k = 0; k < int'(NUM_CH); k++) r_ch_cnt[k] <= '0;
      end else if (!bus.freeze_i) begin
        r_cycle_cnt <= f_inc(r_cycle_cnt);
        for (int k = 0; k < int'(NUM_CH); k++) begin
          if (bus.ev_i[k]) r_ch_cnt[k] <= f_inc(r_ch_cnt[k]);
        end
      end
    end
  end

  // Sticky stall flag and captured PC of the most recent stall entry.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_seen <= 1'b0;
      r_stall_pc   <= '0;
    end else if (w_active) begin
      if (bus.clear_i) begin
        r_stall_seen <= 1'b0;
        r_stall_pc   <= '0;
      end else if (w_enter_stall) begin
        r_stall_seen <= 1'b1;
        r_stall_pc   <= bus.pc_i;
      end
    end
  end

  // Channel readback mux; out-of-range selects read zero.
  always_comb begin
    w_ch_cnt = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (bus.sel_i == SEL_W'(k)) w_ch_cnt = r_ch_cnt[k];
    end
  end

  assign sys_rst_n_o      = r_sys_rst_n;
  assign bus.cycle_cnt_o  = r_cycle_cnt;
  assign bus.ch_cnt_o     = w_ch_cnt;
  assign bus.stall_o      = r_stall;
  assign bus.stall_seen_o = r_stall_seen;
  assign bus.stall_pc_o   = r_stall_pc;
endmodule

// File: tb/tb_cycle_watch.sv
// tb_cycle_watch: directed + randomized checks of cycle_watch against a behavioural model.
`timescale 1ns/1ps

module tb_cycle_watch;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned NUM_CH      = 4;
  localparam int unsigned PC_W        = 32;
  localparam int unsigned STALL_LIMIT = 8;
  localparam int unsigned RST_HOLD    = 16;
  localparam int unsigned REL_EDGES   = 2 + RST_HOLD;
  localparam int unsigned CMAX        = (1 << CNT_W) - 1;

  logic clk_in = 1'b0;
  logic rst_n;
  logic sys_rst_n_o;

  always #5 clk_in = ~clk_in;

  cycle_watch_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH), .PC_W(PC_W)) bus ();

  cycle_watch #(
    .CNT_W(CNT_W), .NUM_CH(NUM_CH), .PC_W(PC_W),
    .STALL_LIMIT(STALL_LIMIT), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .sys_rst_n_o (sys_rst_n_o),
    .bus         (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int unsigned m_edges;
  int unsigned m_cyc;
  int unsigned m_ch [NUM_CH];
  int unsigned m_same;
  int unsigned m_prev_pc;
  int unsigned m_spc;
  bit          m_stalled;
  bit          m_seen;
  logic [31:0] g_pc;

  function automatic int unsigned f_inc(int unsigned v);
`ifdef CYCLE_WATCH_SAT_EN
    return (v == CMAX) ? v : v + 1;
`else
    return (v + 1) % (CMAX + 1);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_edges = 0; m_cyc = 0; m_same = 0; m_prev_pc = 0; m_spc = 0;
    m_stalled = 1'b0; m_seen = 1'b0;
    for (int k = 0; k < int'(NUM_CH); k++) m_ch[k] = 0;
  endtask

  // One rising edge of the specified behaviour.
  task automatic m_edge(input logic [31:0] pc, input logic [3:0] ev, input bit clr, input bit frz);
    bit active;
    bit eq;
    active = (m_edges >= REL_EDGES);
    eq     = (pc == m_prev_pc);
    if (active) begin
      if (clr) begin
        m_cyc = 0; m_same = 0; m_stalled = 1'b0; m_seen = 1'b0; m_spc = 0;
        for (int k = 0; k < int'(NUM_CH); k++) m_ch[k] = 0;
      end else begin
        if (!frz) begin
          m_cyc = f_inc(m_cyc);
          for (int k = 0; k < int'(NUM_CH); k++) if (ev[k]) m_ch[k] = f_inc(m_ch[k]);
        end
        m_same = eq ? ((m_same + 1 > STALL_LIMIT - 1) ? STALL_LIMIT - 1 : m_same + 1) : 0;
        if (m_stalled) m_stalled = eq;
        else if (m_same == STALL_LIMIT - 1) begin
          m_stalled = 1'b1; m_seen = 1'b1; m_spc = pc;
        end
      end
    end
    m_prev_pc = pc;
    if (m_edges < 100000) m_edges++;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_sys"},   64'(sys_rst_n_o),      64'(m_edges >= REL_EDGES));
    chk({tag, "_cyc"},   64'(bus.cycle_cnt_o),  64'(m_cyc));
    chk({tag, "_ch"},    64'(bus.ch_cnt_o),     64'(m_ch[bus.sel_i]));
    chk({tag, "_stall"}, 64'(bus.stall_o),      64'(m_stalled));
    chk({tag, "_seen"},  64'(bus.stall_seen_o), 64'(m_seen));
    chk({tag, "_spc"},   64'(bus.stall_pc_o),   64'(m_spc));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_sys"},   64'(sys_rst_n_o),      64'(0));
    chk({tag, "_cyc"},   64'(bus.cycle_cnt_o),  64'(0));
    chk({tag, "_ch"},    64'(bus.ch_cnt_o),     64'(0));
    chk({tag, "_stall"}, 64'(bus.stall_o),      64'(0));
    chk({tag, "_seen"},  64'(bus.stall_seen_o), 64'(0));
    chk({tag, "_spc"},   64'(bus.stall_pc_o),   64'(0));
  endtask

  // Drive at negedge, advance one edge, sample 1 ns later.
  task automatic step(input logic [31:0] pc, input logic [3:0] ev, input bit clr,
                      input bit frz, input logic [1:0] sel, input string tag);
    @(negedge clk_in);
    bus.pc_i = pc; bus.ev_i = ev; bus.clear_i = clr; bus.freeze_i = frz; bus.sel_i = sel;
    @(posedge clk_in);
    m_edge(pc, ev, clr, frz);
    #1;
    chk_model(tag);
  endtask

  function automatic logic [31:0] nxt_pc();
    g_pc = g_pc + 32'd4;
    return g_pc;
  endfunction

  initial begin
    logic [31:0] pc_r;
    rst_n = 1'b0;
    bus.pc_i = '0; bus.ev_i = '0; bus.clear_i = 1'b0; bus.freeze_i = 1'b0; bus.sel_i = '0;
    g_pc = 32'h0000_1000;
    m_reset();
    #12;
    chk_reset("rst0");

    // Reset release: SoC reset rises after edge 18, first count on edge 19.
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    m_reset();
    for (int i = 1; i <= 19; i++) begin
      step(nxt_pc(), 4'b0, 1'b0, 1'b0, 2'd0, "rel");
      if (i == 17) chk("rel_e17_low", 64'(sys_rst_n_o), 64'(0));
      if (i == 18) begin
        chk("rel_e18_high", 64'(sys_rst_n_o), 64'(1));
        chk("rel_e18_cyc0", 64'(bus.cycle_cnt_o), 64'(0));
      end
      if (i == 19) chk("rel_e19_cyc1", 64'(bus.cycle_cnt_o), 64'(1));
    end

    // Events on channel 2 with freeze over two of the five pulses.
    step(nxt_pc(), 4'b0, 1'b1, 1'b0, 2'd0, "ev_clr");
    for (int i = 0; i < 10; i++)
      step(nxt_pc(), (i % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0, (i == 4 || i == 6), 2'd2, "ev");
    for (int k = 0; k < 4; k++) begin
      step(nxt_pc(), 4'b0, 1'b0, 1'b1, 2'(k), "ev_rd");
      chk($sformatf("ev_ch%0d", k), 64'(bus.ch_cnt_o), (k == 2) ? 64'(3) : 64'(0));
    end
    chk("ev_cyc8", 64'(bus.cycle_cnt_o), 64'(8));

    // Stall after STALL_LIMIT-1 edges of a frozen PC, released by a PC change.
    step(32'h8000_0010, 4'b0, 1'b0, 1'b0, 2'd0, "st_t");
    for (int j = 1; j <= 7; j++) begin
      step(32'h8000_0010, 4'b0, 1'b0, 1'b0, 2'd0, "st_hold");
      chk($sformatf("st_edge%0d", j), 64'(bus.stall_o), (j == 7) ? 64'(1) : 64'(0));
    end
    chk("st_pc", 64'(bus.stall_pc_o), 64'h8000_0010);
    step(32'h8000_0014, 4'b0, 1'b0, 1'b0, 2'd0, "st_rel");
    chk("st_rel_stall", 64'(bus.stall_o), 64'(0));
    chk("st_rel_seen", 64'(bus.stall_seen_o), 64'(1));

    // Clear together with an event while stalled.
    for (int j = 1; j <= 7; j++) step(32'h8000_0014, 4'b0, 1'b0, 1'b0, 2'd0, "cl_hold");
    chk("cl_pre_stall", 64'(bus.stall_o), 64'(1));
    step(32'h8000_0014, 4'b0001, 1'b1, 1'b0, 2'd0, "cl");
    chk("cl_cyc", 64'(bus.cycle_cnt_o), 64'(0));
    chk("cl_ch0", 64'(bus.ch_cnt_o), 64'(0));
    chk("cl_stall", 64'(bus.stall_o), 64'(0));
    chk("cl_seen", 64'(bus.stall_seen_o), 64'(0));
    chk("cl_spc", 64'(bus.stall_pc_o), 64'(0));

    // Wrap or saturate after 20 counted cycles.
    step(nxt_pc(), 4'b0, 1'b1, 1'b0, 2'd0, "wr_clr");
    for (int i = 0; i < 20; i++) step(nxt_pc(), 4'b0, 1'b0, 1'b0, 2'd0, "wr");
`ifdef CYCLE_WATCH_SAT_EN
    chk("wr_cyc", 64'(bus.cycle_cnt_o), 64'(15));
`else
    chk("wr_cyc", 64'(bus.cycle_cnt_o), 64'(4));
`endif

    // Randomized traffic with long PC runs to provoke stalls.
    pc_r = 32'h0000_2000;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) >= 8) pc_r = {28'h0000200, 2'($urandom_range(0, 3)), 2'b00};
      step(pc_r, 4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 3),
           ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), "rnd");
    end

    // Mid-run reset pulse between edges, then the HOLD sequence again.
    rst_n = 1'b0;
    #2;
    chk_reset("mid_rst");
    #1;
    rst_n = 1'b1;
    m_reset();
    for (int i = 1; i <= 20; i++) begin
      step(nxt_pc(), 4'b1111, 1'b0, 1'b0, 2'd1, "rel2");
      if (i == 17) chk("rel2_e17_low", 64'(sys_rst_n_o), 64'(0));
      if (i == 18) chk("rel2_e18_high", 64'(sys_rst_n_o), 64'(1));
      if (i == 20) chk("rel2_ch1", 64'(bus.ch_cnt_o), 64'(2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
